dmi_req_handler: RTL and testbench
==================================

Name: dmi_req_handler

Overview:
- Consumer/producer at the far end of the debug request and response queues.
- Pops one DMI request from the request FIFO and performs the register access on the debug-module register bus.
- Pushes exactly one DMI response into the response FIFO per popped request.
- Only one access is outstanding at a time; it is the bridge between the DMI transport queues and the debug-module register file.

Parameters:
ADDR_W, 7, DMI register address width
DATA_W, 32, DMI data width
TIMEOUT, 255, max cycles spent in REQ+WAIT_R before the access is failed (>=2)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous reset, active low
flush_i  in  1  synchronous abort; return to IDLE
req_empty_i  in  1  request FIFO empty
req_data_i  in  ADDR_W+DATA_W+2  request {addr, data, op}; op: 0 NOP, 1 read, 2 write, 3 reserved
req_pop_o  out  1  pop request FIFO
rsp_full_i  in  1  response FIFO full
rsp_data_o  out  DATA_W+2  response {data, resp}; resp: 0 success, 2 failed
rsp_push_o  out  1  push response FIFO
dm_req_o  out  1  register access request
dm_we_o  out  1  1 = write
dm_addr_o  out  ADDR_W  register address
dm_wdata_o  out  DATA_W  write data
dm_gnt_i  in  1  request accepted
dm_rvalid_i  in  1  access complete
dm_rdata_i  in  DATA_W  read data, valid with dm_rvalid_i
dm_err_i  in  1  access error, valid with dm_rvalid_i
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_ni=0): state IDLE, all latched registers 0, timeout counter 0. All outputs 0.
- Clock/reset: single clock clk_i; reset is asynchronous, active low (rst_ni).
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE:
  - req_pop_o = !req_empty_i && !flush_i (combinational).
  - On pop, latch addr/data/op from req_data_i.
  - op=1 or op=2: go to REQ.
  - op=0: go to RESP with {0, 0}.
  - op=3: go to RESP with {0, 2}.
- REQ:
  - dm_req_o=1; dm_we_o=(op==2); dm_addr_o and dm_wdata_o come from the latched request.
  - All four are held stable until dm_gnt_i=1, then go to WAIT_R.
  - dm_addr_o, dm_wdata_o and dm_we_o are 0 outside REQ.
- WAIT_R:
  - dm_req_o=0. dm_rvalid_i is sampled only in this state; the earliest is the cycle after grant.
  - On dm_rvalid_i, latch the response and go to RESP:
    - data = read ? dm_rdata_i : 0
    - resp = dm_err_i ? 2 : 0
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ/WAIT_R.
  - If it reaches TIMEOUT-1 without grant+completion that cycle, latch {0, 2} and go to RESP; dm_req_o drops.
  - Completion (dm_rvalid_i in WAIT_R) beats timeout in the same cycle.
  - Counter width is clog2(TIMEOUT+1).
- RESP:
  - rsp_data_o is held stable; rsp_push_o = !rsp_full_i && !flush_i.
  - On push, go to IDLE. No pop occurs in RESP or in the push cycle.
  - Back-to-back: the next pop is possible the cycle after the push.
- Latency: minimum pop-to-push is 3 cycles for a read/write (pop c0, grant c1, rvalid c2, push c3). NOP/reserved push in c1.
- rsp_data_o is 0 in all states except RESP.
- flush_i (synchronous, highest priority after reset):
  - Next state is IDLE and the counter clears.
  - req_pop_o and rsp_push_o are forced 0 that cycle; the latched response is discarded.
  - dm_req_o is 0 from the next cycle.
  - A late dm_rvalid_i arriving in IDLE is ignored.
- Ignored inputs: dm_gnt_i outside REQ; dm_rvalid_i outside WAIT_R.

Test Plan:
- Write: req {0x10, 0xDEADBEEF, 2}, grant in first REQ cycle, rvalid the next cycle → dm_we_o=1, dm_addr_o=0x10, dm_wdata_o=0xDEADBEEF; rsp {0, 0} pushed 3 cycles after pop.
- Read, grant delayed 3 cycles, rvalid with 0x12345678 → dm_req_o/dm_addr_o stable 4 cycles; rsp {0x12345678, 0}. Repeat with dm_err_i=1 → rsp {0x12345678, 2}.
- NOP then op=3 back-to-back → no dm_req_o; rsp {0, 0} pushed cycle after first pop, second pop next cycle, rsp {0, 2}.
- rsp_full_i high 5 cycles in RESP → rsp_push_o=0, rsp_data_o unchanged, req_pop_o=0 with FIFO non-empty; push occurs on the first not-full cycle.
- TIMEOUT=8, never grant → dm_req_o high exactly 8 cycles, then rsp {0, 2}.
- Flush and reset:
  - flush_i in WAIT_R, then rvalid → busy_o=0 next cycle, no push, rvalid ignored.
  - rst_ni low mid-REQ → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/dmi_req_handler.sv
// rtl/dmi_req_handler.sv - DMI request/response queue bridge to the debug-module register bus
//
// Purpose:
//   Pops one DMI request from the request FIFO, performs the register access on the
//   debug-module bus, and pushes exactly one response per popped request. Only one
//   access is outstanding at a time.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              synchronous abort back to IDLE
//   req_empty_i          request FIFO empty
//   req_data_i           request {addr, data, op}; op 0 NOP, 1 read, 2 write, 3 reserved
//   req_pop_o            pop request FIFO
//   rsp_full_i           response FIFO full
//   rsp_data_o           response {data, resp}; resp 0 success, 2 failed
//   rsp_push_o           push response FIFO
//   dm_req_o, dm_we_o    register access request / write enable
//   dm_addr_o            register address
//   dm_wdata_o           write data
//   dm_gnt_i             request accepted
//   dm_rvalid_i          access complete
//   dm_rdata_i           read data (with dm_rvalid_i)
//   dm_err_i             access error (with dm_rvalid_i)
//   busy_o               handler not idle
module dmi_req_handler #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     req_empty_i,
    input  logic [ADDR_W+DATA_W+1:0] req_data_i,
    output logic                     req_pop_o,
    input  logic                     rsp_full_i,
    output logic [DATA_W+1:0]        rsp_data_o,
    output logic                     rsp_push_o,
    output logic                     dm_req_o,
    output logic                     dm_we_o,
    output logic [ADDR_W-1:0]        dm_addr_o,
    output logic [DATA_W-1:0]        dm_wdata_o,
    input  logic                     dm_gnt_i,
    input  logic                     dm_rvalid_i,
    input  logic [DATA_W-1:0]        dm_rdata_i,
    input  logic                     dm_err_i,
    output logic                     busy_o
);

    localparam int REQ_W = ADDR_W + DATA_W + 2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W+1:0]   rsp_q, rsp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [1:0]          req_op;
    logic                timeout_hit;

    assign req_addr  = req_data_i[REQ_W-1 -: ADDR_W];
    assign req_wdata = req_data_i[DATA_W+1:2];
    assign req_op    = req_data_i[1:0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        rsp_d       = rsp_q;
        cnt_d       = cnt_q;
        req_pop_o   = 1'b0;
        rsp_push_o  = 1'b0;
        rsp_data_o  = '0;
        dm_req_o    = 1'b0;
        dm_we_o     = 1'b0;
        dm_addr_o   = '0;
        dm_wdata_o  = '0;
        busy_o      = (state_q != S_IDLE);
        timeout_hit = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                // Gated by rst_ni so every output reads 0 while reset is asserted.
                req_pop_o = rst_ni && !req_empty_i && !flush_i;
                if (req_pop_o) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    op_d    = req_op;
                    if (req_op == OP_READ || req_op == OP_WRITE) begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                    end else if (req_op == OP_NOP) begin
                        rsp_d   = {{DATA_W{1'b0}}, RESP_OK};
                        state_d = S_RESP;
                    end else begin
                        rsp_d   = {{DATA_W{1'b0}}, RESP_FAIL};
                        state_d = S_RESP;
                    end
                end
            end

            S_REQ: begin
                dm_req_o   = 1'b1;
                dm_we_o    = (op_q == OP_WRITE);
                dm_addr_o  = addr_q;
                dm_wdata_o = wdata_q;
                cnt_d      = cnt_q + CNT_W'(1);
                // A grant alone is not a completion, so the timeout still wins here.
                if (timeout_hit) begin
                    rsp_d   = {{DATA_W{1'b0}}, RESP_FAIL};
                    state_d = S_RESP;
                end else if (dm_gnt_i) begin
                    state_d = S_WAIT_R;
                end
            end

            S_WAIT_R: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion beats a timeout landing in the same cycle.
                if (dm_rvalid_i) begin
                    rsp_d   = {(op_q == OP_READ) ? dm_rdata_i : {DATA_W{1'b0}},
                               dm_err_i ? RESP_FAIL : RESP_OK};
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rsp_d   = {{DATA_W{1'b0}}, RESP_FAIL};
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                rsp_data_o = rsp_q;
                rsp_push_o = rst_ni && !rsp_full_i && !flush_i;
                if (rsp_push_o) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rsp_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            rsp_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rsp_q   <= rsp_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dmi_req_handler.sv
// tb/tb_dmi_req_handler.sv - directed self-checking bench for dmi_req_handler
module tb_dmi_req_handler;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic                     req_empty;
    logic [ADDR_W+DATA_W+1:0] req_data;
    logic                     req_pop;
    logic                     rsp_full;
    logic [DATA_W+1:0]        rsp_data;
    logic                     rsp_push;
    logic                     dm_req;
    logic                     dm_we;
    logic [ADDR_W-1:0]        dm_addr;
    logic [DATA_W-1:0]        dm_wdata;
    logic                     dm_gnt;
    logic                     dm_rvalid;
    logic [DATA_W-1:0]        dm_rdata;
    logic                     dm_err;
    logic                     busy;

    int errors = 0;
    int checks = 0;

    dmi_req_handler #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .req_empty_i(req_empty),
        .req_data_i (req_data),
        .req_pop_o  (req_pop),
        .rsp_full_i (rsp_full),
        .rsp_data_o (rsp_data),
        .rsp_push_o (rsp_push),
        .dm_req_o   (dm_req),
        .dm_we_o    (dm_we),
        .dm_addr_o  (dm_addr),
        .dm_wdata_o (dm_wdata),
        .dm_gnt_i   (dm_gnt),
        .dm_rvalid_i(dm_rvalid),
        .dm_rdata_i (dm_rdata),
        .dm_err_i   (dm_err),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_empty = 1'b0; req_data = {7'h10, 32'hDEADBEEF, 2'd2};
        #1;
        checks++; if (req_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", req_pop); end
        checks++; if ({dm_req, dm_we, dm_addr, dm_wdata} !== '0) begin errors++; $display("FAIL reset_dm: got %b/%b/%h/%h expected all 0", dm_req, dm_we, dm_addr, dm_wdata); end
        checks++; if ({rsp_push, rsp_data, busy} !== '0) begin errors++; $display("FAIL reset_rsp: got push=%b data=%h busy=%b expected 0", rsp_push, rsp_data, busy); end
        step(); rst_n = 1'b1; req_empty = 1'b1;
    endtask

    task automatic test_write();
        step(); req_empty = 1'b0; req_data = {7'h10, 32'hDEADBEEF, 2'd2}; #1;
        checks++; if (req_pop !== 1'b1) begin errors++; $display("FAIL wr_pop: got %b expected 1", req_pop); end
        step(); req_empty = 1'b1; dm_gnt = 1'b1; #1;
        checks++; if ({dm_req, dm_we} !== 2'b11) begin errors++; $display("FAIL wr_req_we: got %b%b expected 11", dm_req, dm_we); end
        checks++; if (dm_addr !== 7'h10 || dm_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_addr_data: got %h/%h expected 10/deadbeef", dm_addr, dm_wdata); end
        step(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hAAAA5555; #1;
        checks++; if ({dm_req, dm_we, rsp_push} !== 3'b000) begin errors++; $display("FAIL wr_wait: got req=%b we=%b push=%b expected 0", dm_req, dm_we, rsp_push); end
        step(); dm_rvalid = 1'b0; #1;
        checks++; if (rsp_push !== 1'b1 || rsp_data !== 34'h0) begin errors++; $display("FAIL wr_rsp: got push=%b data=%h expected 1/0", rsp_push, rsp_data); end
        step(); #1;
        checks++; if (busy !== 1'b0 || rsp_push !== 1'b0) begin errors++; $display("FAIL wr_idle: got busy=%b push=%b expected 0/0", busy, rsp_push); end
    endtask

    task automatic test_read(input logic err, input logic [DATA_W+1:0] exp_rsp);
        step(); req_empty = 1'b0; req_data = {7'h22, 32'h0, 2'd1}; #1;
        checks++; if (req_pop !== 1'b1) begin errors++; $display("FAIL rd_pop: got %b expected 1", req_pop); end
        for (int i = 0; i < 4; i++) begin
            step(); req_empty = 1'b1; dm_gnt = (i == 3); #1;
            checks++; if (dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 7'h22) begin errors++; $display("FAIL rd_hold%0d: got req=%b we=%b addr=%h expected 1/0/22", i, dm_req, dm_we, dm_addr); end
        end
        step(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h12345678; dm_err = err; #1;
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b expected 0", dm_req); end
        step(); dm_rvalid = 1'b0; dm_err = 1'b0; dm_rdata = 32'h0; #1;
        checks++; if (rsp_push !== 1'b1 || rsp_data !== exp_rsp) begin errors++; $display("FAIL rd_rsp: got push=%b data=%h expected 1/%h", rsp_push, rsp_data, exp_rsp); end
    endtask

    task automatic test_back_to_back();
        step(); req_empty = 1'b0; req_data = {7'h05, 32'h11111111, 2'd0}; #1;
        checks++; if (req_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop1: got %b expected 1", req_pop); end
        step(); req_data = {7'h06, 32'h22222222, 2'd3}; #1;
        checks++; if (rsp_push !== 1'b1 || rsp_data !== 34'h0 || req_pop !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL b2b_rsp1: got push=%b data=%h pop=%b req=%b expected 1/0/0/0", rsp_push, rsp_data, req_pop, dm_req); end
        step(); #1;
        checks++; if (req_pop !== 1'b1) begin errors++; $display("FAIL b2b_pop2: got %b expected 1", req_pop); end
        step(); req_empty = 1'b1; #1;
        checks++; if (rsp_push !== 1'b1 || rsp_data !== 34'h2 || dm_req !== 1'b0) begin errors++; $display("FAIL b2b_rsp2: got push=%b data=%h req=%b expected 1/2/0", rsp_push, rsp_data, dm_req); end
        step(); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_rsp_full();
        step(); req_empty = 1'b0; req_data = {7'h07, 32'h33333333, 2'd3}; #1;
        checks++; if (req_pop !== 1'b1) begin errors++; $display("FAIL full_pop: got %b expected 1", req_pop); end
        step(); req_data = {7'h08, 32'h0, 2'd0}; rsp_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            #1;
            checks++; if (rsp_push !== 1'b0 || rsp_data !== 34'h2 || req_pop !== 1'b0) begin errors++; $display("FAIL full_hold%0d: got push=%b data=%h pop=%b expected 0/2/0", i, rsp_push, rsp_data, req_pop); end
        end
        step(); rsp_full = 1'b0; #1;
        checks++; if (rsp_push !== 1'b1 || rsp_data !== 34'h2 || req_pop !== 1'b0) begin errors++; $display("FAIL full_push: got push=%b data=%h pop=%b expected 1/2/0", rsp_push, rsp_data, req_pop); end
        step(); #1;
        checks++; if (req_pop !== 1'b1) begin errors++; $display("FAIL full_next_pop: got %b expected 1", req_pop); end
        step(); req_empty = 1'b1; #1;
        checks++; if (rsp_push !== 1'b1 || rsp_data !== 34'h0) begin errors++; $display("FAIL full_nop_rsp: got push=%b data=%h expected 1/0", rsp_push, rsp_data); end
    endtask

    task automatic test_timeout();
        int high;
        high = 0;
        step(); req_empty = 1'b0; req_data = {7'h33, 32'h0, 2'd1}; #1;
        checks++; if (req_pop !== 1'b1) begin errors++; $display("FAIL to_pop: got %b expected 1", req_pop); end
        for (int i = 0; i < 9; i++) begin
            step(); req_empty = 1'b1; #1;
            if (dm_req === 1'b1) high++;
        end
        checks++; if (high !== 8) begin errors++; $display("FAIL to_req_cycles: got %0d expected 8", high); end
        checks++; if (rsp_push !== 1'b1 || rsp_data !== 34'h2) begin errors++; $display("FAIL to_rsp: got push=%b data=%h expected 1/2", rsp_push, rsp_data); end
        step(); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_flush();
        step(); req_empty = 1'b0; req_data = {7'h44, 32'h0, 2'd1}; #1;
        step(); req_empty = 1'b1; dm_gnt = 1'b1; #1;
        step(); dm_gnt = 1'b0; flush = 1'b1; #1;
        checks++; if (req_pop !== 1'b0 || rsp_push !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fl_cycle: got pop=%b push=%b busy=%b expected 0/0/1", req_pop, rsp_push, busy); end
        step(); flush = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hCAFEF00D; #1;
        checks++; if (busy !== 1'b0 || dm_req !== 1'b0 || rsp_push !== 1'b0) begin errors++; $display("FAIL fl_idle: got busy=%b req=%b push=%b expected 0/0/0", busy, dm_req, rsp_push); end
        step(); dm_rvalid = 1'b0; #1;
        checks++; if (busy !== 1'b0 || rsp_push !== 1'b0 || rsp_data !== 34'h0) begin errors++; $display("FAIL fl_late_rvalid: got busy=%b push=%b data=%h expected 0/0/0", busy, rsp_push, rsp_data); end
    endtask

    task automatic test_async_reset();
        step(); req_empty = 1'b0; req_data = {7'h55, 32'h0, 2'd2}; #1;
        step(); req_empty = 1'b1; #1;
        checks++; if (dm_req !== 1'b1 || dm_addr !== 7'h55) begin errors++; $display("FAIL ar_in_req: got req=%b addr=%h expected 1/55", dm_req, dm_addr); end
        #1 rst_n = 1'b0; req_empty = 1'b0; #1;
        checks++; if ({dm_req, dm_we, dm_addr, dm_wdata, busy, req_pop, rsp_push, rsp_data} !== '0) begin errors++; $display("FAIL ar_outputs: got req=%b we=%b addr=%h busy=%b pop=%b push=%b expected all 0", dm_req, dm_we, dm_addr, busy, req_pop, rsp_push); end
        step(); rst_n = 1'b1; req_empty = 1'b1; #1;
        checks++; if (busy !== 1'b0 || dm_req !== 1'b0) begin errors++; $display("FAIL ar_after: got busy=%b req=%b expected 0/0", busy, dm_req); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_empty = 1'b1; req_data = '0; rsp_full = 1'b0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0; dm_err = 1'b0;
        test_reset();
        test_write();
        test_read(1'b0, {32'h12345678, 2'd0});
        test_read(1'b1, {32'h12345678, 2'd2});
        test_back_to_back();
        test_rsp_full();
        test_timeout();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
